// File: rtl/fft_input_loader.sv
// Frame loader ahead of the first radix-4 FFT stage. Serial in, 4 words/cycle out. Macro: FFT_INPUT_SCALE_EN (>>>2 pre-scale on entry).
// Latency: burst starts 2 cycles after drain_en is seen in WAIT (registered bank reads); ld_done 1 cycle after the burst.
// Backpressure: in_ready only in LOAD; burst waits on drain_en, then runs N/4 cycles unbroken.
module fft_input_loader #(
    parameter int WORDSIZE   = 16,
    parameter int NUMSAMPLES = 256,
    parameter int BANKADDR   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_data,
    input  logic                drain_en,
    output logic                wr_en,
    output logic [WORDSIZE-1:0] data_out0,
    output logic [WORDSIZE-1:0] data_out1,
    output logic [WORDSIZE-1:0] data_out2,
    output logic [WORDSIZE-1:0] data_out3,
    output logic                ld_done,
    output logic                busy
);
    localparam int NQ = NUMSAMPLES / 4;
    localparam int CW = BANKADDR + 2;
    localparam logic [CW-1:0]       LAST_N = CW'(NUMSAMPLES - 1);
    localparam logic [BANKADDR-1:0] LAST_K = BANKADDR'(NQ - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       n_cnt;
    logic [BANKADDR-1:0] k_cnt;
    logic [WORDSIZE-1:0] bank [4][NQ];
    logic [WORDSIZE-1:0] wdata;
    logic                accept;

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

`ifdef FFT_INPUT_SCALE_EN
    assign wdata = WORDSIZE'($signed(in_data) >>> 2);
`else
    assign wdata = in_data;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_data) state_nxt = LOAD;
            LOAD:    if (accept && n_cnt == LAST_N) state_nxt = WAIT;
            WAIT:    if (drain_en) state_nxt = DRAIN;
            DRAIN:   if (k_cnt == LAST_K) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_cnt     <= '0;
            k_cnt     <= '0;
            wr_en     <= 1'b0;
            ld_done   <= 1'b0;
            data_out0 <= '0;
            data_out1 <= '0;
            data_out2 <= '0;
            data_out3 <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && ld_data)
                n_cnt <= '0;
            else if (accept)
                n_cnt <= n_cnt + 1'b1;

            if (state == WAIT && drain_en)
                k_cnt <= '0;
            else if (state == DRAIN)
                k_cnt <= k_cnt + 1'b1;

            // Outputs are forced to zero outside the wr_en window.
            wr_en   <= (state == DRAIN);
            ld_done <= (state == DONE);
            if (state == DRAIN) begin
                data_out0 <= bank[0][k_cnt];
                data_out1 <= bank[1][k_cnt];
                data_out2 <= bank[2][k_cnt];
                data_out3 <= bank[3][k_cnt];
            end else begin
                data_out0 <= '0;
                data_out1 <= '0;
                data_out2 <= '0;
                data_out3 <= '0;
            end
        end
    end

    // Bank select is the top two index bits, so bank j holds x[j*N/4 .. (j+1)*N/4-1].
    always_ff @(posedge clk) begin
        if (rst_n && accept)
            bank[n_cnt[CW-1 -: 2]][n_cnt[BANKADDR-1:0]] <= wdata;
    end
endmodule
